// File: rtl/microsequencer.sv
// Microprogram sequencer: uPC, next-address select and return-address stack.
// Define USEQ_STACK_EN to build the CALL/RET stack; without it CALL acts as BR and RET as NEXT.
module microsequencer #(
    parameter int ADDR_W = 4,
    parameter int CTRL_W = 22,
    parameter int NCOND  = 3,
    parameter int DEPTH  = 4,
    localparam int CSEL_W = $clog2(NCOND + 1),
    localparam int SP_W   = $clog2(DEPTH + 1),
    localparam int UW     = 2 + 1 + CSEL_W + ADDR_W + CTRL_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [UW-1:0]     uword,
    input  logic [NCOND-1:0]  cond,
    input  logic              hold,
    input  logic              clr_err,
    output logic [ADDR_W-1:0] upc,
    output logic [CTRL_W-1:0] ctrl_out,
    output logic [SP_W-1:0]   sp,
    output logic              err_ovf,
    output logic              err_unf
);
    localparam int         CVEC_W  = 1 << CSEL_W;
    localparam logic [1:0] OP_BR   = 2'b01;
    localparam logic [1:0] OP_CALL = 2'b10;
    localparam logic [1:0] OP_RET  = 2'b11;

    logic [1:0]        op;
    logic              inv;
    logic [CSEL_W-1:0] csel;
    logic [ADDR_W-1:0] baddr;
    logic [CTRL_W-1:0] ctrl;
    logic [CVEC_W-1:0] cvec;
    logic              c;
    logic [ADDR_W-1:0] upc_q, upc_d, inc;

    assign {op, inv, csel, baddr, ctrl} = uword;

    // Padding the condition vector to a power of two makes csel > NCOND read as false.
    assign cvec     = CVEC_W'({cond, 1'b1});
    assign c        = cvec[csel] ^ inv;
    assign inc      = upc_q + 1'b1;
    assign upc      = upc_q;
    assign ctrl_out = hold ? '0 : ctrl;

`ifdef USEQ_STACK_EN
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [ADDR_W-1:0] stack_q [DEPTH];
    logic [SP_W-1:0]   sp_q, sp_d;
    logic              ovf_q, unf_q;
    logic              ovf_set, unf_set, push;
    logic              full, empty;
    logic [IDX_W-1:0]  push_idx, pop_idx;

    assign push_idx = IDX_W'(sp_q);
    assign pop_idx  = IDX_W'(sp_q - 1'b1);
    assign full     = (sp_q == SP_W'(DEPTH));
    assign empty    = (sp_q == '0);

    always_comb begin
        upc_d   = upc_q;
        sp_d    = sp_q;
        push    = 1'b0;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        if (!hold) begin
            upc_d = inc;
            case (op)
                OP_BR: if (c) upc_d = baddr;
                OP_CALL: begin
                    if (c && full) begin
                        ovf_set = 1'b1;
                    end else if (c) begin
                        push  = 1'b1;
                        sp_d  = sp_q + 1'b1;
                        upc_d = baddr;
                    end
                end
                OP_RET: begin
                    if (c && empty) begin
                        unf_set = 1'b1;
                        upc_d   = '0;
                    end else if (c) begin
                        sp_d  = sp_q - 1'b1;
                        upc_d = stack_q[pop_idx];
                    end
                end
                default: ;
            endcase
        end
    end

    // Stack storage carries no reset; entries at or above sp are don't-care.
    always_ff @(posedge clk) begin
        if (push) stack_q[push_idx] <= inc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            upc_q <= '0;
            sp_q  <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            upc_q <= upc_d;
            sp_q  <= sp_d;
            ovf_q <= ovf_set | (ovf_q & ~clr_err);
            unf_q <= unf_set | (unf_q & ~clr_err);
        end
    end

    assign sp      = sp_q;
    assign err_ovf = ovf_q;
    assign err_unf = unf_q;
`else
    logic unused_clr;

    always_comb begin
        upc_d = upc_q;
        if (!hold) begin
            upc_d = inc;
            case (op)
                OP_BR, OP_CALL: if (c) upc_d = baddr;
                OP_RET:         upc_d = inc;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) upc_q <= '0;
        else        upc_q <= upc_d;
    end

    assign unused_clr = clr_err;
    assign sp         = '0;
    assign err_ovf    = 1'b0;
    assign err_unf    = 1'b0;
`endif
endmodule

// File: tb/tb_microsequencer.sv
// Bench for microsequencer: directed vector tables plus random programs against a queue-based model.
module tb_microsequencer;
    localparam int ADDR_W = 4;
    localparam int CTRL_W = 22;
    localparam int NCOND  = 3;
    localparam int DEPTH  = 4;
    localparam int CSEL_W = 2;
    localparam int SP_W   = 3;
    localparam int UW     = 2 + 1 + CSEL_W + ADDR_W + CTRL_W;
    localparam int NW     = 1 << ADDR_W;
`ifdef USEQ_STACK_EN
    localparam bit STACK_EN = 1'b1;
`else
    localparam bit STACK_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic [UW-1:0]     uword;
    logic [NCOND-1:0]  cond;
    logic              hold;
    logic              clr_err;
    logic [ADDR_W-1:0] upc;
    logic [CTRL_W-1:0] ctrl_out;
    logic [SP_W-1:0]   sp;
    logic              err_ovf;
    logic              err_unf;

    logic [UW-1:0] rom [NW];
    assign uword = rom[upc];

    always #5 clk = ~clk;

    microsequencer #(.ADDR_W(ADDR_W), .CTRL_W(CTRL_W), .NCOND(NCOND), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .uword(uword), .cond(cond), .hold(hold), .clr_err(clr_err),
        .upc(upc), .ctrl_out(ctrl_out), .sp(sp), .err_ovf(err_ovf), .err_unf(err_unf)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic             h;
        logic             clr;
        logic [NCOND-1:0] cnd;
        int               upc;
        int               sp;
        logic             ovf;
        logic             unf;
    } vec_t;
    vec_t vq[$];

    // Behavioural model state
    int m_upc;
    int m_stk[$];
    bit m_ovf, m_unf;

    function automatic logic [UW-1:0] mkw(input int op, input int inv, input int csel,
                                          input int baddr, input int ctrl);
        return {2'(op), 1'(inv), CSEL_W'(csel), ADDR_W'(baddr), CTRL_W'(ctrl)};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input int eu, input int es,
                                 input logic eo, input logic eun, input logic eh);
        logic [CTRL_W-1:0] ec;
        ec = eh ? '0 : rom[eu][CTRL_W-1:0];
        check({tag, ".upc"}, 64'(upc), 64'(eu));
        check({tag, ".sp"}, 64'(sp), 64'(es));
        check({tag, ".ovf"}, 64'(err_ovf), 64'(eo));
        check({tag, ".unf"}, 64'(err_unf), 64'(eun));
        check({tag, ".ctrl"}, 64'(ctrl_out), 64'(ec));
    endtask

    task automatic add(input logic h, input logic clr, input logic [NCOND-1:0] cn,
                       input int u, input int s, input logic o, input logic un);
        vq.push_back('{h, clr, cn, u, s, o, un});
    endtask

    task automatic run_vecs(input string tag);
        foreach (vq[i]) begin
            hold    = vq[i].h;
            clr_err = vq[i].clr;
            cond    = vq[i].cnd;
            #1;
            check_outputs($sformatf("%s[%0d]", tag, i), vq[i].upc, vq[i].sp,
                          vq[i].ovf, vq[i].unf, vq[i].h);
            @(posedge clk);
            @(negedge clk);
        end
        vq.delete();
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        hold    = 1'b0;
        clr_err = 1'b0;
        #1;
        check_outputs("rst_async", 0, 0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        check_outputs("rst_held", 0, 0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        m_upc = 0;
        m_stk.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic rom_all_next();
        for (int i = 0; i < NW; i++) rom[i] = mkw(0, 0, 0, 0, int'($urandom));
    endtask

    // One clock of the architectural rules, expressed with a queue as the LIFO.
    task automatic model_clock(input logic h, input logic clr, input logic [NCOND-1:0] cv);
        longint w;
        int op, inv, csel, baddr, nxt;
        bit c, so, su;
        w     = longint'(rom[m_upc]);
        baddr = int'((w >> CTRL_W) % (1 << ADDR_W));
        csel  = int'((w >> (CTRL_W + ADDR_W)) % (1 << CSEL_W));
        inv   = int'((w >> (CTRL_W + ADDR_W + CSEL_W)) % 2);
        op    = int'(w >> (UW - 2));
        if (csel == 0)          c = 1'b1;
        else if (csel <= NCOND) c = cv[csel-1];
        else                    c = 1'b0;
        c   = c ^ (inv != 0);
        nxt = (m_upc + 1) % NW;
        so  = 1'b0;
        su  = 1'b0;
        if (!h) begin
            case (op)
                0: m_upc = nxt;
                1: m_upc = c ? baddr : nxt;
                2: begin
                    if (!c) m_upc = nxt;
                    else if (!STACK_EN) m_upc = baddr;
                    else if (m_stk.size() == DEPTH) begin so = 1'b1; m_upc = nxt; end
                    else begin m_stk.push_back(nxt); m_upc = baddr; end
                end
                default: begin
                    if (!c || !STACK_EN) m_upc = nxt;
                    else if (m_stk.size() == 0) begin su = 1'b1; m_upc = 0; end
                    else m_upc = m_stk.pop_back();
                end
            endcase
        end
        if (STACK_EN) begin
            m_ovf = so | (m_ovf & !clr);
            m_unf = su | (m_unf & !clr);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, upc=%0d", upc);
        $fatal(1);
    end

    initial begin
        hold    = 1'b0;
        clr_err = 1'b0;
        cond    = '0;
        rom_all_next();
        @(negedge clk);

        // Sequential walk with wrap
        do_reset();
        for (int i = 0; i <= NW; i++) add(0, 0, 3'b000, i % NW, 0, 0, 0);
        run_vecs("seq");

        // Conditional branch, unconditional branch and a 3-cycle hold
        rom[3] = mkw(1, 1, 2, 9, int'($urandom));
        rom[5] = mkw(1, 0, 0, 1, int'($urandom));
        do_reset();
        add(0, 0, 3'b010, 0, 0, 0, 0);
        add(0, 0, 3'b010, 1, 0, 0, 0);
        add(0, 0, 3'b010, 2, 0, 0, 0);
        add(0, 0, 3'b010, 3, 0, 0, 0);
        add(0, 0, 3'b010, 4, 0, 0, 0);
        add(0, 0, 3'b010, 5, 0, 0, 0);
        add(0, 0, 3'b010, 1, 0, 0, 0);
        add(1, 0, 3'b000, 2, 0, 0, 0);
        add(1, 0, 3'b000, 2, 0, 0, 0);
        add(1, 0, 3'b000, 2, 0, 0, 0);
        add(0, 0, 3'b000, 2, 0, 0, 0);
        add(0, 0, 3'b000, 3, 0, 0, 0);
        add(0, 0, 3'b000, 9, 0, 0, 0);
        add(0, 0, 3'b000, 10, 0, 0, 0);
        run_vecs("br");

        // Nested call / return with a hold while a return address is stacked
        rom_all_next();
        rom[2]  = mkw(2, 0, 0, 8, int'($urandom));
        rom[8]  = mkw(2, 0, 0, 12, int'($urandom));
        rom[12] = mkw(3, 0, 0, 0, int'($urandom));
        rom[9]  = mkw(3, 0, 0, 0, int'($urandom));
        do_reset();
        add(0, 0, 3'b000, 0, 0, 0, 0);
        add(0, 0, 3'b000, 1, 0, 0, 0);
        add(0, 0, 3'b000, 2, 0, 0, 0);
`ifdef USEQ_STACK_EN
        add(1, 0, 3'b000, 8, 1, 0, 0);
        add(1, 0, 3'b000, 8, 1, 0, 0);
        add(0, 0, 3'b000, 8, 1, 0, 0);
        add(0, 0, 3'b000, 12, 2, 0, 0);
        add(0, 0, 3'b000, 9, 1, 0, 0);
        add(0, 0, 3'b000, 3, 0, 0, 0);
        add(0, 0, 3'b000, 4, 0, 0, 0);
`else
        add(1, 0, 3'b000, 8, 0, 0, 0);
        add(1, 0, 3'b000, 8, 0, 0, 0);
        add(0, 0, 3'b000, 8, 0, 0, 0);
        add(0, 0, 3'b000, 12, 0, 0, 0);
        add(0, 0, 3'b000, 13, 0, 0, 0);
        add(0, 0, 3'b000, 14, 0, 0, 0);
`endif
        run_vecs("call");

        // Stack limits: even words CALL w+2, odd words RET
        rom_all_next();
        for (int w = 0; w <= 8; w += 2) rom[w] = mkw(2, 0, 0, w + 2, int'($urandom));
        for (int w = 1; w <= 9; w += 2) rom[w] = mkw(3, 0, 0, 0, int'($urandom));
        do_reset();
`ifdef USEQ_STACK_EN
        add(0, 0, 3'b000, 0, 0, 0, 0);
        add(0, 0, 3'b000, 2, 1, 0, 0);
        add(0, 0, 3'b000, 4, 2, 0, 0);
        add(0, 0, 3'b000, 6, 3, 0, 0);
        add(1, 0, 3'b000, 8, 4, 0, 0);
        add(0, 0, 3'b000, 8, 4, 0, 0);
        add(0, 0, 3'b000, 9, 4, 1, 0);
        add(0, 0, 3'b000, 7, 3, 1, 0);
        add(0, 0, 3'b000, 5, 2, 1, 0);
        add(0, 0, 3'b000, 3, 1, 1, 0);
        add(0, 0, 3'b000, 1, 0, 1, 0);
        add(0, 1, 3'b000, 0, 0, 1, 1);
        add(0, 0, 3'b000, 2, 1, 0, 0);
        add(0, 0, 3'b000, 4, 2, 0, 0);
        add(0, 0, 3'b000, 6, 3, 0, 0);
        add(0, 1, 3'b000, 8, 4, 0, 0);
        add(1, 1, 3'b000, 9, 4, 1, 0);
        add(0, 0, 3'b000, 9, 4, 0, 0);
        add(0, 0, 3'b000, 7, 3, 0, 0);
`else
        add(0, 0, 3'b000, 0, 0, 0, 0);
        add(0, 0, 3'b000, 2, 0, 0, 0);
        add(0, 0, 3'b000, 4, 0, 0, 0);
        add(0, 0, 3'b000, 6, 0, 0, 0);
        add(1, 0, 3'b000, 8, 0, 0, 0);
        add(0, 0, 3'b000, 8, 0, 0, 0);
        for (int u = 10; u < NW; u++) add(0, 0, 3'b000, u, 0, 0, 0);
        add(0, 1, 3'b000, 0, 0, 0, 0);
        add(0, 0, 3'b000, 2, 0, 0, 0);
`endif
        run_vecs("lim");

        // Random programs against the model, with a reset in the middle
        for (int n = 0; n < 600; n++) begin
            if (n % 100 == 0) begin
                for (int i = 0; i < NW; i++) rom[i] = UW'($urandom);
            end
            if (n == 0 || n == 300) do_reset();
            hold    = ($urandom_range(0, 4) == 0);
            clr_err = ($urandom_range(0, 9) == 0);
            cond    = NCOND'($urandom);
            #1;
            check_outputs($sformatf("rnd[%0d]", n), m_upc, m_stk.size(), m_ovf, m_unf, hold);
            @(posedge clk);
            model_clock(hold, clr_err, cond);
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
